// File: rtl/wino_ctrl_pkg.sv
// rtl/wino_ctrl_pkg.sv - shared state type and default parameters for the Winograd sequencer
package wino_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREPARE,
    ST_START,
    ST_COMPLETE,
    ST_FINISH
  } wino_ctrl_state_t;

  localparam int DEF_ID_W        = 4;
  localparam int DEF_OD_W        = 8;
  localparam int DEF_DIM_W       = 9;
  localparam int DEF_OD_PAR      = 2;
  localparam int DEF_START_DELAY = 4;

endpackage

// File: rtl/wino_delay_line.sv
// rtl/wino_delay_line.sv - DEPTH-stage single-bit shift register with synchronous clear
module wino_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(din);
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/wino_seq_controller.sv
// rtl/wino_seq_controller.sv - layer sequencer over ID/OD passes with go/abort handshake
// Optional stall counter built when WINO_CTRL_STALL_CNT_EN is defined.
module wino_seq_controller
  import wino_ctrl_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int OD_W        = DEF_OD_W,
  parameter int DIM_W       = DEF_DIM_W,
  parameter int OD_PAR      = DEF_OD_PAR,
  parameter int START_DELAY = DEF_START_DELAY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ID_W-1:0]   cfg_total_id_i,
  input  logic [OD_W-1:0]   cfg_total_od_i,
  input  logic [DIM_W-1:0]  cfg_width_i,
  input  logic [DIM_W-1:0]  cfg_height_i,
  input  logic              cfg_wen_i,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic              weight_ready_i,
  input  logic              data_ready_i,
  input  logic              data_complete_i,
  output logic [ID_W-1:0]   weight_id_o,
  output logic [ID_W-1:0]   data_id_o,
  output logic [OD_W-1:0]   weight_od_base_o,
  output logic [OD_PAR-1:0] weight_od_mask_o,
  output logic              weight_prepare_o,
  output logic              data_prepare_o,
  output logic              weight_start_o,
  output logic              data_start_o,
  output logic [DIM_W-1:0]  width_o,
  output logic [DIM_W-1:0]  height_o,
  output logic              busy_o,
  output logic              conv_completed_o,
  output logic [31:0]       stall_cnt_o
);

  wino_ctrl_state_t state;
  logic [ID_W-1:0]  cfg_id_q, id_q;
  logic [OD_W-1:0]  cfg_od_q, od_base_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic [ID_W:0]    tot_id_eff;
  logic [OD_W:0]    tot_od_eff;
  logic             idle_like, accept_go, od_wrap, last_pass;

  assign idle_like  = (state == ST_IDLE) || (state == ST_FINISH);
  assign accept_go  = idle_like && go_i && !abort_i;
  assign tot_id_eff = (cfg_id_q == '0) ? (ID_W+1)'(1) : {1'b0, cfg_id_q};
  assign tot_od_eff = (cfg_od_q == '0) ? (OD_W+1)'(1) : {1'b0, cfg_od_q};
  // One extra bit keeps od_base+OD_PAR and id+1 from wrapping at the top of range
  assign od_wrap    = ({1'b0, od_base_q} + (OD_W+1)'(OD_PAR)) >= tot_od_eff;
  assign last_pass  = od_wrap && (({1'b0, id_q} + (ID_W+1)'(1)) >= tot_id_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cfg_id_q  <= '0;
      cfg_od_q  <= '0;
      width_q   <= '0;
      height_q  <= '0;
      id_q      <= '0;
      od_base_q <= '0;
    end else begin
      if (idle_like && cfg_wen_i) begin
        cfg_id_q <= cfg_total_id_i;
        cfg_od_q <= cfg_total_od_i;
        width_q  <= cfg_width_i;
        height_q <= cfg_height_i;
      end
      if (abort_i) begin
        state     <= ST_IDLE;
        id_q      <= '0;
        od_base_q <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_FINISH: begin
            if (go_i) begin
              state     <= ST_PREPARE;
              id_q      <= '0;
              od_base_q <= '0;
            end
          end
          ST_PREPARE:  if (weight_ready_i && data_ready_i) state <= ST_START;
          ST_START:    if (data_complete_i) state <= ST_COMPLETE;
          ST_COMPLETE: begin
            state <= last_pass ? ST_FINISH : ST_PREPARE;
            if (od_wrap) begin
              od_base_q <= '0;
              id_q      <= id_q + ID_W'(1);
            end else begin
              od_base_q <= od_base_q + OD_W'(OD_PAR);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Mask is only meaningful during a run; forced low while idle or finished
  always_comb begin
    weight_od_mask_o = '0;
    for (int k = 0; k < OD_PAR; k++) begin
      weight_od_mask_o[k] = busy_o && (({1'b0, od_base_q} + (OD_W+1)'(k)) < tot_od_eff);
    end
  end

  wino_delay_line #(.DEPTH(START_DELAY)) u_start_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (abort_i),
    .din     (state == ST_START),
    .dout    (data_start_o)
  );

  assign weight_id_o      = id_q;
  assign data_id_o        = id_q;
  assign weight_od_base_o = od_base_q;
  assign weight_prepare_o = (state == ST_PREPARE);
  assign data_prepare_o   = (state == ST_PREPARE);
  assign weight_start_o   = (state == ST_START);
  assign width_o          = width_q;
  assign height_o         = height_q;
  assign busy_o           = !idle_like;
  assign conv_completed_o = (state == ST_FINISH);

`ifdef WINO_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (accept_go) begin
      stall_q <= '0;
    end else if ((state == ST_PREPARE) && !(weight_ready_i && data_ready_i) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wino_seq_controller.sv
// tb/tb_wino_seq_controller.sv - self-checking bench for wino_seq_controller
module tb_wino_seq_controller;

  localparam int IDW = 4;
  localparam int ODW = 8;
  localparam int DW  = 9;
  localparam int P   = 2;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [IDW-1:0] cfg_total_id_i = '0;
  logic [ODW-1:0] cfg_total_od_i = '0;
  logic [DW-1:0]  cfg_width_i = '0;
  logic [DW-1:0]  cfg_height_i = '0;
  logic           cfg_wen_i = 1'b0;
  logic           go_i = 1'b0;
  logic           abort_i = 1'b0;
  logic           weight_ready_i = 1'b0;
  logic           data_ready_i = 1'b0;
  logic           data_complete_i = 1'b0;
  logic [IDW-1:0] weight_id_o, data_id_o;
  logic [ODW-1:0] weight_od_base_o;
  logic [P-1:0]   weight_od_mask_o;
  logic           weight_prepare_o, data_prepare_o, weight_start_o, data_start_o;
  logic [DW-1:0]  width_o, height_o;
  logic           busy_o, conv_completed_o;
  logic [31:0]    stall_cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  wino_seq_controller #(
    .ID_W(IDW), .OD_W(ODW), .DIM_W(DW), .OD_PAR(P), .START_DELAY(D)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_total_id_i(cfg_total_id_i), .cfg_total_od_i(cfg_total_od_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
    .cfg_wen_i(cfg_wen_i), .go_i(go_i), .abort_i(abort_i),
    .weight_ready_i(weight_ready_i), .data_ready_i(data_ready_i),
    .data_complete_i(data_complete_i),
    .weight_id_o(weight_id_o), .data_id_o(data_id_o),
    .weight_od_base_o(weight_od_base_o), .weight_od_mask_o(weight_od_mask_o),
    .weight_prepare_o(weight_prepare_o), .data_prepare_o(data_prepare_o),
    .weight_start_o(weight_start_o), .data_start_o(data_start_o),
    .width_o(width_o), .height_o(height_o),
    .busy_o(busy_o), .conv_completed_o(conv_completed_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // data_start_o must equal the START level seen D clock edges earlier; abort empties the history
  bit hist[$] = '{0, 0, 0, 0};
  always @(posedge clk) begin
    if (!reset_n || abort_i) hist = '{0, 0, 0, 0};
    else begin
      hist.push_back(weight_start_o);
      void'(hist.pop_front());
    end
  end
  always @(negedge clk) if (reset_n) chk("data_start_dly", longint'(data_start_o), longint'(hist[0]));

  typedef struct {
    int         tid;
    int         tod;
    bit         rnd;
    int         passes;
    logic [1:0] last_mask;
  } vec_t;

  task automatic start_layer(input int tid, input int tod, input bit wen);
    @(negedge clk);
    cfg_total_id_i = IDW'(tid);
    cfg_total_od_i = ODW'(tod);
    cfg_wen_i = wen;
    go_i = 1'b1;
    @(negedge clk);
    cfg_wen_i = 1'b0;
    go_i = 1'b0;
  endtask

  task automatic wait_rise(input string nm);
    int c = 0;
    while (!weight_start_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_start_seen"}, longint'(weight_start_o), 1);
  endtask

  task automatic run_layer(input int tid, input int tod, input bit rnd,
                           output int npass, output logic [P-1:0] lastmask);
    int eb[$];
    int ei[$];
    logic [P-1:0] em[$];
    logic [P-1:0] m;
    int t_id, t_od, exp_stall;
    logic [DW-1:0] w, h;
    bit prev, done;
    t_id = (tid == 0) ? 1 : tid;
    t_od = (tod == 0) ? 1 : tod;
    for (int i = 0; i < t_id; i++) begin
      for (int b = 0; b < t_od; b += P) begin
        for (int k = 0; k < P; k++) m[k] = (b + k < t_od);
        eb.push_back(b);
        ei.push_back(i);
        em.push_back(m);
      end
    end
    w = DW'($urandom);
    h = DW'($urandom);
    cfg_width_i = w;
    cfg_height_i = h;
    start_layer(tid, tod, 1'b1);
    chk("busy_after_go", longint'(busy_o), 1);
    npass = 0;
    lastmask = '0;
    prev = 1'b0;
    done = 1'b0;
    exp_stall = 0;
    for (int c = 0; c < 5000; c++) begin
      if (weight_start_o && !prev) begin
        if (eb.size() == 0) chk("extra_pass", 1, 0);
        else begin
          chk("od_base", longint'(weight_od_base_o), eb[0]);
          chk("weight_id", longint'(weight_id_o), ei[0]);
          chk("data_id", longint'(data_id_o), ei[0]);
          chk("od_mask", longint'(weight_od_mask_o), longint'(em[0]));
          void'(eb.pop_front());
          void'(ei.pop_front());
          void'(em.pop_front());
        end
        npass++;
        lastmask = weight_od_mask_o;
      end
      prev = weight_start_o;
      if (conv_completed_o) begin
        done = 1'b1;
        break;
      end
      weight_ready_i  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_ready_i    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_complete_i = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (weight_prepare_o && !(weight_ready_i && data_ready_i)) exp_stall++;
      @(negedge clk);
    end
    chk("run_done", longint'(done), 1);
    chk("passes_left", eb.size(), 0);
    chk("busy_in_finish", longint'(busy_o), 0);
    chk("width_o", longint'(width_o), longint'(w));
    chk("height_o", longint'(height_o), longint'(h));
`ifdef WINO_CTRL_STALL_CNT_EN
    chk("stall_cnt_run", longint'(stall_cnt_o), exp_stall);
`else
    chk("stall_cnt_run", longint'(stall_cnt_o), 0);
`endif
  endtask

  initial begin
    vec_t vecs[8];
    int np, nws, nds, fws, fds, lws, lds;
    logic [P-1:0] lm;

    vecs[0] = '{2, 4, 1'b0, 4, 2'b11};
    vecs[1] = '{1, 5, 1'b1, 3, 2'b01};
    vecs[2] = '{0, 0, 1'b1, 1, 2'b01};
    vecs[3] = '{3, 1, 1'b1, 3, 2'b01};
    vecs[4] = '{1, 2, 1'b1, 1, 2'b11};
    vecs[5] = '{2, 7, 1'b1, 8, 2'b01};
    vecs[6] = '{15, 3, 1'b1, 30, 2'b01};
    vecs[7] = '{4, 255, 1'b0, 512, 2'b01};

    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_done", longint'(conv_completed_o), 0);
    chk("rst_prep", longint'(weight_prepare_o | data_prepare_o), 0);
    chk("rst_start", longint'(weight_start_o | data_start_o), 0);
    chk("rst_mask", longint'(weight_od_mask_o), 0);
    chk("rst_ids", longint'(weight_id_o | data_id_o), 0);
    chk("rst_base", longint'(weight_od_base_o), 0);
    chk("rst_dims", longint'(width_o | height_o), 0);
    chk("rst_stall", longint'(stall_cnt_o), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", longint'(busy_o), 0);

    foreach (vecs[i]) begin
      run_layer(vecs[i].tid, vecs[i].tod, vecs[i].rnd, np, lm);
      chk($sformatf("vec%0d_passes", i), np, vecs[i].passes);
      chk($sformatf("vec%0d_last_mask", i), longint'(lm), longint'(vecs[i].last_mask));
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_finish_hold", i), longint'(conv_completed_o), 1);
    end

    // START held 6 cycles: data_start_o high 6 cycles, offset by D
    weight_ready_i = 1'b1;
    data_ready_i = 1'b1;
    data_complete_i = 1'b0;
    start_layer(1, 1, 1'b1);
    nws = 0; nds = 0; fws = -1; fds = -1; lws = -1; lds = -1;
    for (int c = 0; c < 40; c++) begin
      if (weight_start_o) begin
        nws++;
        if (fws < 0) fws = c;
        lws = c;
      end
      if (data_start_o) begin
        nds++;
        if (fds < 0) fds = c;
        lds = c;
      end
      data_complete_i = weight_start_o && (nws == 6);
      @(negedge clk);
    end
    chk("dly_start_cycles", nws, 6);
    chk("dly_dstart_cycles", nds, 6);
    chk("dly_rise_offset", fds - fws, D);
    chk("dly_fall_offset", lds - lws, D);

    // abort in the middle of the second pass's START
    data_complete_i = 1'b0;
    start_layer(1, 4, 1'b1);
    wait_rise("abort_p1");
    data_complete_i = 1'b1;
    @(negedge clk);
    data_complete_i = 1'b0;
    wait_rise("abort_p2");
    chk("abort_p2_base", longint'(weight_od_base_o), 2);
    repeat (D) @(negedge clk);
    chk("abort_pre_dstart", longint'(data_start_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", longint'(busy_o), 0);
    chk("abort_done", longint'(conv_completed_o), 0);
    chk("abort_wstart", longint'(weight_start_o), 0);
    chk("abort_dstart", longint'(data_start_o), 0);
    chk("abort_ids", longint'(weight_id_o | data_id_o), 0);
    chk("abort_base", longint'(weight_od_base_o), 0);
    chk("abort_mask", longint'(weight_od_mask_o), 0);

    // cfg write during START is ignored
    start_layer(1, 2, 1'b1);
    wait_rise("cfgwen");
    cfg_total_od_i = 8'd8;
    cfg_wen_i = 1'b1;
    @(negedge clk);
    cfg_wen_i = 1'b0;
    data_complete_i = 1'b1;
    np = 1;
    for (int c = 0; c < 60 && !conv_completed_o; c++) begin
      @(negedge clk);
      if (weight_start_o) np++;
    end
    chk("cfgwen_done", longint'(conv_completed_o), 1);
    chk("cfgwen_passes", np, 1);
    start_layer(1, 8, 1'b0);
    np = 0;
    for (int c = 0; c < 60 && !conv_completed_o; c++) begin
      if (weight_start_o) np++;
      @(negedge clk);
    end
    chk("cfgwen_rerun_passes", np, 1);

    // data_ready_i low for 7 cycles of the first PREPARE
    weight_ready_i = 1'b1;
    data_ready_i = 1'b0;
    start_layer(1, 1, 1'b1);
    np = 0;
    for (int c = 0; c < 40 && !conv_completed_o; c++) begin
      if (weight_prepare_o) begin
        if (np < 7) np++;
        else data_ready_i = 1'b1;
      end
      @(negedge clk);
    end
    chk("stall_done", longint'(conv_completed_o), 1);
`ifdef WINO_CTRL_STALL_CNT_EN
    chk("stall_cnt7", longint'(stall_cnt_o), 7);
`else
    chk("stall_cnt7", longint'(stall_cnt_o), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wino_seq_controller.md
# wino_seq_controller

Parametrised successor to the Winograd main controller. It sequences one convolution layer over input-depth (ID) and output-depth (OD) channels, processing OD_PAR output channels per pass, and hands prepare/start phases to the weight and data controllers. It adds an explicit go/abort handshake, an idle state, ragged-tail OD masking and a configurable data-start delay. It sits between off-chip configuration and the weight/data controllers.

## Interface
- ID_W, 4, width of ID count/index
- OD_W, 8, width of OD count/index
- DIM_W, 9, width of layer width/height
- OD_PAR, 2, output channels per pass (≥1)
- START_DELAY, 4, cycles from START entry to data_start_o (≥1)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_total_id_i  in  ID_W  number of input channels (0 treated as 1)
- cfg_total_od_i  in  OD_W  number of output channels (0 treated as 1)
- cfg_width_i, cfg_height_i  in  DIM_W  layer dimensions (registered, passed through)
- cfg_wen_i  in  1  load cfg_* into registers; ignored unless state is IDLE or FINISH
- go_i  in  1  start a layer (sampled in IDLE/FINISH)
- abort_i  in  1  cancel run, highest priority
- weight_ready_i, data_ready_i, data_complete_i  in  1  controller handshakes
- weight_id_o, data_id_o  out  ID_W  current ID index
- weight_od_base_o  out  OD_W  first OD index of the pass
- weight_od_mask_o  out  OD_PAR  bit k = (od_base+k < total_od)
- weight_prepare_o, data_prepare_o  out  1  high in PREPARE
- weight_start_o  out  1  high in START
- data_start_o  out  1  START level delayed START_DELAY cycles
- width_o, height_o  out  DIM_W  registered dimensions
- busy_o  out  1  state ∉ {IDLE, FINISH}
- conv_completed_o  out  1  high in FINISH
- stall_cnt_o  out  32  PREPARE cycles waiting on ready (see Configuration)

## Operation
- States: IDLE, PREPARE, START, COMPLETE, FINISH. Reset → IDLE.
- IDLE/FINISH: go_i → PREPARE, with od_base=0 and id=0.
- PREPARE: weight_ready_i && data_ready_i → START.
- START: data_complete_i → COMPLETE.
- COMPLETE (one cycle): last = (od_base+OD_PAR ≥ total_od) && (id+1 ≥ total_id), compared at OD_W+1 / ID_W+1 bits with no wrap. If last → FINISH, else → PREPARE. Counters update on exit: if od_base+OD_PAR ≥ total_od then od_base=0 and id+=1, else od_base+=OD_PAR.
- FINISH holds until go_i.
- abort_i in any state → IDLE next cycle; counters and delay line cleared; cfg registers kept.
- Simultaneous cfg_wen_i and go_i in IDLE: the new cfg is used for the run.
- Reset values: every output 0; cfg registers 0.

## Timing
- Prepare/start outputs are combinational from state (Moore).
- data_start_o rises exactly START_DELAY cycles after the first START cycle and falls START_DELAY cycles after START exits.
- Passes = ceil(total_od/OD_PAR)·total_id. Minimum pass length is 3 cycles (PREPARE, START, COMPLETE) with readies and complete already high.

## Configuration
- WINO_CTRL_STALL_CNT_EN: when defined, stall_cnt_o counts cycles spent in PREPARE with either ready low. It clears on go_i, saturates at 2^32−1 and holds in FINISH.
- When undefined, stall_cnt_o is tied to 0 and no counter logic is built.

## Structure
- Package wino_ctrl_pkg: state enum wino_ctrl_state_t and the default parameter constants.
- Sub-module wino_delay_line (parameter DEPTH): shift register with sync clear, used for data_start_o.

## Test plan
- total_id=2, total_od=4, OD_PAR=2, readies tied high, go pulse -> 4 passes with (od_base,id) = (0,0),(2,0),(0,1),(2,1); masks all 2'b11; then conv_completed_o=1 and busy_o=0.
- total_od=5, total_id=1, OD_PAR=2 -> 3 passes with masks 11, 11, 01; od_base = 0, 2, 4.
- START_DELAY=4, START held 6 cycles -> data_start_o high for 6 cycles, starting 4 cycles after weight_start_o rises.
- abort_i asserted mid-START of pass 2 -> IDLE next cycle, data_start_o low the same cycle, all indices 0.
- cfg_wen_i during START with total_od=8 -> ignored; the run finishes using the original total_od.
- WINO_CTRL_STALL_CNT_EN defined, data_ready_i held low 7 cycles in the first PREPARE -> stall_cnt_o=7.
